ifu: RTL

Instruction fetch unit for the cpuX pipeline. Holds the PC, runs a one-outstanding-request handshake to instruction memory, and keeps the fetched word in an instruction register until decode consumes it. It feeds the immediate field (`imm`) to the immediate extender. It takes the extender's 32-bit output back to form branch targets, so it sits directly upstream of the extender and also consumes what the extender produces.

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/ifu_if.sv | 21 ++
 rtl/ifu_npc.sv | 28 ++
 rtl/ifu.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  // Fetch control states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StValid,
    StDrain
  } ifu_state_e;

  // Next-PC source select.
  typedef enum logic [2:0] {
    NpcSeq,
    NpcBr,
    NpcJ,
    NpcJr,
    NpcExc
  } npc_sel_e;

  // Clear the byte offset of a register-supplied target.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction memory request/response bundle.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_npc.sv
// Combinational next-PC selector.
module ifu_npc
  import ifu_pkg::*;
#(
  parameter logic [31:0] ExcPc = EXC_PC
) (
  input  logic [31:0] pc4_i,
  input  logic [31:0] eximm_i,
  input  logic [25:0] jtarget_i,
  input  logic [31:0] jr_addr_i,
  input  npc_sel_e    sel_i,
  output logic [31:0] npc_o
);

  // Pick the target; branch offset is the word-scaled immediate, wrapping mod 2^32.
  always_comb begin
    npc_o = pc4_i;
    unique case (sel_i)
      NpcSeq:  npc_o = pc4_i;
      NpcBr:   npc_o = pc4_i + {eximm_i[29:0], 2'b00};
      NpcJ:    npc_o = {pc4_i[31:28], jtarget_i, 2'b00};
      NpcJr:   npc_o = word_align(jr_addr_i);
      NpcExc:  npc_o = ExcPc;
      default: npc_o = pc4_i;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, single-outstanding imem handshake, instruction register.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] ResetPc = RESET_PC,
  parameter logic [31:0] ExcPc   = EXC_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         branch_i,
  input  logic [31:0]  eximm_i,
  input  logic         jump_i,
  input  logic [25:0]  jtarget_i,
  input  logic         jr_i,
  input  logic [31:0]  jr_addr_i,
  input  logic         flush_i,
  ifu_if.master        imem,
  output logic [31:0]  instr_o,
  output logic [31:0]  pc_o,
  output logic [31:0]  pc4_o,
  output logic [15:0]  imm_o,
  output logic         instr_valid_o
);

  ifu_state_e  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;

  npc_sel_e    npc_sel;
  logic        load_npc;
  logic [31:0] npc;
  logic [31:0] pc4;

  assign pc4 = pc_q + 32'd4;

  ifu_npc #(
    .ExcPc (ExcPc)
  ) u_npc (
    .pc4_i     (pc4),
    .eximm_i   (eximm_i),
    .jtarget_i (jtarget_i),
    .jr_addr_i (jr_addr_i),
    .sel_i     (npc_sel),
    .npc_o     (npc)
  );

  // Next-state, data capture and next-PC selection.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    npc_sel    = NpcSeq;
    load_npc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (flush_i) begin
          npc_sel  = NpcExc;
          load_npc = 1'b1;
        end
      end
      StFetch: begin
        if (flush_i) begin
          // Without an ack the request must stay up unchanged until memory answers.
          if (imem.imem_ack) begin
            npc_sel  = NpcExc;
            load_npc = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end else if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = StValid;
        end
      end
      StValid: begin
        if (flush_i) begin
          npc_sel  = NpcExc;
          load_npc = 1'b1;
          state_d  = StFetch;
        end else if (!stall_i) begin
          load_npc = 1'b1;
          state_d  = StFetch;
          if (jr_i) begin
            npc_sel = NpcJr;
          end else if (jump_i) begin
            npc_sel = NpcJ;
          end else if (branch_i) begin
            npc_sel = NpcBr;
          end else begin
            npc_sel = NpcSeq;
          end
        end
      end
      StDrain: begin
        if (imem.imem_ack) begin
          npc_sel  = NpcExc;
          load_npc = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_npc) begin
      fetch_pc_d = npc;
    end
    instr_valid_d = (state_d == StValid);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= ResetPc;
      instr_q       <= '0;
      pc_q          <= ResetPc;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem.imem_req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem.imem_addr = fetch_pc_q;
  assign instr_o        = instr_q;
  assign pc_o           = pc_q;
  assign pc4_o          = pc4;
  assign imm_o          = instr_q[15:0];
  assign instr_valid_o  = instr_valid_q;

endmodule
